// File: rtl/alu_sequencer_if.sv
// Command channel between the instruction-decode front end and alu_sequencer.
// The front end is the master (drives the command fields and valid); the
// sequencer is the slave (drives ready). A command transfers on the rising
// clock edge where valid && ready.
interface alu_sequencer_if #(
  parameter int RAW = 3
);
  logic           valid;
  logic           ready;
  logic [4:0]     f;
  logic [RAW-1:0] dst;
  logic [RAW-1:0] src1;
  logic [RAW-1:0] src2;
  logic [15:0]    imm;

  modport master (
    output valid, f, dst, src1, src2, imm,
    input  ready
  );

  modport slave (
    input  valid, f, dst, src1, src2, imm,
    output ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue controller in front of a combinational 16-bit ALU.
// Each command reads two operands from an internal register file, presents them
// to the ALU for one cycle (EXEC), captures the result, and writes it back (WB).
// F = 5'b11111 is LOADI: the latched immediate is written back and the flags
// are left untouched. Illegal function codes are rejected with a one-cycle err.
//
// Optional build macro: ALU_SEQ_CMD_FIFO_EN adds a 4-entry command FIFO in
// front of the FSM, so the front end can queue commands while one executes.
module alu_sequencer #(
  parameter int NREGS = 8,
  parameter int RAW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  cmd,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [4:0]      alu_f,
  output logic            alu_cin,
  input  logic [15:0]     alu_result,
  input  logic [5:0]      alu_status,
  output logic            done,
  output logic            err,
  output logic [15:0]     res_out,
  output logic [5:0]      status,
  input  logic [RAW-1:0]  dbg_addr,
  output logic [15:0]     dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [4:0] F_LOADI = 5'b11111;

  // Legal function codes of the ALU plus LOADI; everything else is rejected.
  function automatic logic is_legal(input logic [4:0] f);
    logic ok;
    case (f)
      5'b00001, 5'b00011,
      5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10000, 5'b10001, 5'b10010, 5'b10011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111,
      F_LOADI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t         state_r;
  state_t         state_s;

  logic [15:0]    rf_r [NREGS];

  // Command latched at the issue edge and the value captured at EXEC->WB.
  logic [RAW-1:0] dst_r;
  logic [15:0]    imm_r;
  logic           loadi_r;
  logic [15:0]    cap_val_r;
  logic [5:0]     cap_status_r;

  // Command currently offered to the FSM and whether it is taken this cycle.
  logic           take_s;
  logic [4:0]     iss_f_s;
  logic [RAW-1:0] iss_dst_s;
  logic [RAW-1:0] iss_src1_s;
  logic [RAW-1:0] iss_src2_s;
  logic [15:0]    iss_imm_s;

`ifdef ALU_SEQ_CMD_FIFO_EN
  // Queued command layout: {f, dst, src1, src2, imm}.
  localparam int EW = 5 + 3 * RAW + 16;

  logic [EW-1:0]  fifo_mem_r [4];
  logic [1:0]     wr_ptr_r;
  logic [1:0]     rd_ptr_r;
  logic [2:0]     count_r;
  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;
  logic [EW-1:0]  head_s;

  assign full_s  = (count_r == 3'd4);
  assign empty_s = (count_r == 3'd0);
  // The FSM pulls the next queued command whenever it is idle.
  assign pop_s   = (state_r == IDLE) && !empty_s;
  // A full queue can still accept when the head leaves in the same cycle.
  assign cmd.ready = !rst && (!full_s || pop_s);
  assign push_s  = cmd.valid && cmd.ready;
  assign head_s  = fifo_mem_r[rd_ptr_r];

  assign take_s     = pop_s;
  assign iss_f_s    = head_s[EW-1 -: 5];
  assign iss_dst_s  = head_s[16 + 3 * RAW - 1 -: RAW];
  assign iss_src1_s = head_s[16 + 2 * RAW - 1 -: RAW];
  assign iss_src2_s = head_s[16 + RAW - 1 -: RAW];
  assign iss_imm_s  = head_s[15:0];

  // Command FIFO storage, pointers and occupancy; reset flushes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= {EW{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {cmd.f, cmd.dst, cmd.src1, cmd.src2, cmd.imm};
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + 3'd1;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - 3'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end
`else
  // Without a queue the FSM takes the command straight off the channel.
  assign cmd.ready  = (state_r == IDLE) && !rst;
  assign take_s     = cmd.valid && (state_r == IDLE);
  assign iss_f_s    = cmd.f;
  assign iss_dst_s  = cmd.dst;
  assign iss_src1_s = cmd.src1;
  assign iss_src2_s = cmd.src2;
  assign iss_imm_s  = cmd.imm;
`endif

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: legal commands run EXEC then WB; illegal ones stay in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s && is_legal(iss_f_s)) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC:    state_s = WB;
      WB:      state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Issue, capture and retire: operand drive, result capture, flags and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a        <= 16'h0000;
      alu_b        <= 16'h0000;
      alu_f        <= 5'b00000;
      alu_cin      <= 1'b0;
      dst_r        <= {RAW{1'b0}};
      imm_r        <= 16'h0000;
      loadi_r      <= 1'b0;
      cap_val_r    <= 16'h0000;
      cap_status_r <= 6'b000000;
      done         <= 1'b0;
      err          <= 1'b0;
      res_out      <= 16'h0000;
      status       <= 6'b000000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Operands are read only in IDLE, i.e. after the previous write-back,
      // so dst == src of a following command always sees the new value.
      if (take_s) begin
        alu_a   <= rf_r[iss_src1_s];
        alu_b   <= rf_r[iss_src2_s];
        alu_f   <= iss_f_s;
        alu_cin <= status[5];
        dst_r   <= iss_dst_s;
        imm_r   <= iss_imm_s;
        loadi_r <= (iss_f_s == F_LOADI);
        err     <= !is_legal(iss_f_s);
      end
      // The ALU has had the whole EXEC cycle to settle.
      if (state_r == EXEC) begin
        cap_val_r    <= loadi_r ? imm_r : alu_result;
        cap_status_r <= alu_status;
        done         <= 1'b1;
      end
      // LOADI leaves the flags alone so a following ADC still sees the carry.
      if (state_r == WB) begin
        res_out <= cap_val_r;
        if (!loadi_r) begin
          status <= cap_status_r;
        end
      end
    end
  end

  // Register file: single write port, written as WB retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= 16'h0000;
      end
    end else if (state_r == WB) begin
      rf_r[dst_r] <= cap_val_r;
    end
  end

  assign dbg_data = rf_r[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. A small behavioural ALU (ADD, ADC, SUB)
// stands in for the real ALU; flags are {C,Z,N,O,P,AC} with P set for an even
// number of ones in the 16-bit result and AC not modelled (held 0).
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_f;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic [5:0]  alu_status;
  logic        done;
  logic        err;
  logic [15:0] res_out;
  logic [5:0]  status;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int vec_cnt = 0;
  int miscompare_cnt = 0;
  logic exec_cin;

  alu_sequencer_if #(.RAW(3)) cmd_if ();

  alu_sequencer #(.NREGS(8), .RAW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_status (alu_status),
    .done       (done),
    .err        (err),
    .res_out    (res_out),
    .status     (status),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU for the handful of functions the vectors use.
  logic [16:0] m_sum;
  logic [15:0] m_res;
  logic        m_c;
  logic        m_o;
  always_comb begin
    m_sum = 17'd0;
    m_res = 16'h0000;
    m_c   = 1'b0;
    m_o   = 1'b0;
    case (alu_f)
      5'b00100: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        m_res = m_sum[15:0];
        m_c   = m_sum[16];
        m_o   = (alu_a[15] == alu_b[15]) && (m_res[15] != alu_a[15]);
      end
      5'b00101: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_cin};
        m_res = m_sum[15:0];
        m_c   = m_sum[16];
        m_o   = (alu_a[15] == alu_b[15]) && (m_res[15] != alu_a[15]);
      end
      5'b00110: begin
        m_sum = {1'b0, alu_a} - {1'b0, alu_b};
        m_res = m_sum[15:0];
        m_c   = m_sum[16];
        m_o   = (alu_a[15] != alu_b[15]) && (m_res[15] != alu_a[15]);
      end
      default: begin
        m_res = alu_a;
      end
    endcase
  end
  assign alu_result = m_res;
  assign alu_status = {m_c, (m_res == 16'h0000), m_res[15], m_o, ~(^m_res), 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rf(input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check($sformatf("rf[%0d]", addr), {16'h0000, dbg_data}, {16'h0000, exp});
  endtask

  // Issue one command from a falling edge and follow it for three cycles.
  task automatic run_cmd(input logic [4:0] f, input logic [2:0] dst, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [15:0] imm, input bit illegal);
    cmd_if.valid = 1'b1;
    cmd_if.f     = f;
    cmd_if.dst   = dst;
    cmd_if.src1  = s1;
    cmd_if.src2  = s2;
    cmd_if.imm   = imm;
    check("ready_idle", {31'd0, cmd_if.ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_if.valid = 1'b0;
    @(negedge clk);
    exec_cin = alu_cin;
    check("alu_f_exec", {27'd0, alu_f}, {27'd0, f});
    check("err_c1", {31'd0, err}, {31'd0, illegal});
    check("done_c1", {31'd0, done}, 32'd0);
    check("ready_c1", {31'd0, cmd_if.ready}, {31'd0, illegal});
    @(negedge clk);
    check("done_c2", {31'd0, done}, {31'd0, !illegal});
    check("err_c2", {31'd0, err}, 32'd0);
    if (!illegal) begin
      check("ready_c2", {31'd0, cmd_if.ready}, 32'd0);
    end
    @(negedge clk);
    check("done_c3", {31'd0, done}, 32'd0);
    check("ready_c3", {31'd0, cmd_if.ready}, 32'd1);
  endtask

  initial begin
    int k;
    rst          = 1'b1;
    cmd_if.valid = 1'b0;
    cmd_if.f     = 5'b00000;
    cmd_if.dst   = 3'd0;
    cmd_if.src1  = 3'd0;
    cmd_if.src2  = 3'd0;
    cmd_if.imm   = 16'h0000;
    dbg_addr     = 3'd0;

    // Reset values while rst is high.
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cmd_if.ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_status", {26'd0, status}, 32'd0);
    check("rst_res", {16'd0, res_out}, 32'd0);
    check("rst_alu_a", {16'd0, alu_a}, 32'd0);
    check("rst_alu_b", {16'd0, alu_b}, 32'd0);
    check("rst_alu_f", {27'd0, alu_f}, 32'd0);
    check("rst_alu_cin", {31'd0, alu_cin}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x7FFF + 0x0001 = 0x8000 with N and O.
    run_cmd(5'b11111, 3'd1, 3'd0, 3'd0, 16'h7FFF, 1'b0);
    check("status_loadi1", {26'd0, status}, 32'd0);
    check("res_loadi1", {16'd0, res_out}, 32'h7FFF);
    run_cmd(5'b11111, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b0);
    check("status_loadi2", {26'd0, status}, 32'd0);
    run_cmd(5'b00100, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0);
    check("res_add1", {16'd0, res_out}, 32'h8000);
    check("status_add1", {26'd0, status}, 32'h0C);
    check_rf(3'd3, 16'h8000);

    // Illegal function code: err only, r5 and flags untouched.
    run_cmd(5'b11111, 3'd5, 3'd0, 3'd0, 16'h1234, 1'b0);
    check("status_loadi5", {26'd0, status}, 32'h0C);
    run_cmd(5'b01100, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b1);
    check_rf(3'd5, 16'h1234);
    check("status_illegal", {26'd0, status}, 32'h0C);
    check("res_illegal", {16'd0, res_out}, 32'h1234);

    // 0xFFFF + 1 = 0 with C, Z, P; then ADC consumes the carry.
    run_cmd(5'b11111, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1'b0);
    run_cmd(5'b11111, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b0);
    run_cmd(5'b00100, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0);
    check_rf(3'd3, 16'h0000);
    check("status_add2", {26'd0, status}, 32'h32);
    run_cmd(5'b00101, 3'd4, 3'd2, 3'd2, 16'h0000, 1'b0);
    check("adc_cin", {31'd0, exec_cin}, 32'd1);
    check_rf(3'd4, 16'h0003);
    check("status_adc", {26'd0, status}, 32'h02);

    // dst == src: old value is the operand (r4 = r4 + r4 = 6).
    run_cmd(5'b00100, 3'd4, 3'd4, 3'd4, 16'h0000, 1'b0);
    check_rf(3'd4, 16'h0006);

    // Back-to-back: valid held high, second accept three cycles after the first.
    @(negedge clk);
    cmd_if.valid = 1'b1;
    cmd_if.f     = 5'b11111;
    cmd_if.dst   = 3'd6;
    cmd_if.imm   = 16'h00AA;
    @(posedge clk);
    #1;
    cmd_if.dst = 3'd7;
    cmd_if.imm = 16'h0055;
    k = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      k++;
      if (cmd_if.ready) break;
    end
    check("b2b_gap", k, 32'd3);
    @(posedge clk);
    #1;
    cmd_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    check_rf(3'd6, 16'h00AA);
    check_rf(3'd7, 16'h0055);

    // Reset during EXEC aborts the command.
    @(negedge clk);
    cmd_if.valid = 1'b1;
    cmd_if.f     = 5'b00110;
    cmd_if.dst   = 3'd1;
    cmd_if.src1  = 3'd2;
    cmd_if.src2  = 3'd3;
    @(posedge clk);
    #1;
    cmd_if.valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", {31'd0, cmd_if.ready}, 32'd0);
    @(negedge clk);
    check("rst_mid_done1", {31'd0, done}, 32'd0);
    check("rst_mid_ready1", {31'd0, cmd_if.ready}, 32'd0);
    @(negedge clk);
    check("rst_mid_done2", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_ready", {31'd0, cmd_if.ready}, 32'd1);
    check("rst_after_done", {31'd0, done}, 32'd0);
    check("rst_after_status", {26'd0, status}, 32'd0);
    check("rst_after_res", {16'd0, res_out}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      check_rf(a[2:0], 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
